mult_share_ctrl: RTL and testbench

- Round-robin controller that shares one 3x3 sequential binary multiplier between NREQ requesters.
- Per operation it captures the granted requester's operands, issues a one-cycle clear pulse to the multiplier, and drives start until done.
- It then returns the product to the granted requester as a one-cycle response.
- Sits between client blocks and the multiplier instance, which is external and wired to the mul_* ports.

---
 rtl/mult_share_pkg.sv | 17 +
 rtl/rr_pick.sv | 35 +++
 rtl/mult_share_ctrl.sv | 149 ++++++++++++++
 tb/tb_mult_share_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the multiplier-sharing controller.
// State encoding is fixed so that debug probes keep their historical values.
package mult_share_pkg;

  localparam int unsigned DEF_NREQ           = 4;
  localparam int unsigned DEF_W              = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr_i,
// wrapping modulo NREQ. Returns a one-hot grant, its index and an any flag.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      pos = sum[PW-1:0];
      if (!any_o && req_i[pos]) begin
        any_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin arbiter sharing one external sequential multiplier between NREQ clients.
// Define MULT_SHARE_TIMEOUT_EN to add a WAIT watchdog that answers with rsp_err.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int unsigned NREQ           = DEF_NREQ,
  parameter int unsigned W              = DEF_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_product,
  output logic              rsp_err,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_clr,
  output logic              mul_start,
  input  logic [2*W-1:0]    mul_product,
  input  logic              mul_done
);

  localparam int unsigned PW = $clog2(NREQ);

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d, gnt_id_q;
  logic [NREQ-1:0] req_ready_q, rsp_valid_q;
  logic [2*W-1:0]  rsp_product_q;
  logic [W-1:0]    mul_a_q, mul_b_q;
  logic            mul_clr_q, mul_start_q;

  logic [NREQ-1:0] pick_gnt, gnt_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic [W-1:0]    op_a [NREQ];
  logic [W-1:0]    op_b [NREQ];

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_a[i] = req_a[i*W +: W];
      op_b[i] = req_b[i*W +: W];
    end
  end

  assign rr_ptr_d = (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + PW'(1);
  assign gnt_oh   = NREQ'(1) << gnt_id_q;

`ifdef MULT_SHARE_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  logic [7:0] timeout_unused;
  assign timeout_unused = 8'(TIMEOUT_CYCLES);
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gnt_id_q      <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_clr_q     <= 1'b0;
      mul_start_q   <= 1'b0;
`ifdef MULT_SHARE_TIMEOUT_EN
      wait_cnt_q    <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: if (pick_any) begin
          req_ready_q <= pick_gnt;
          mul_a_q     <= op_a[pick_idx];
          mul_b_q     <= op_b[pick_idx];
          gnt_id_q    <= pick_idx;
          rr_ptr_q    <= rr_ptr_d;
          mul_clr_q   <= 1'b1;
          state_q     <= CLEAR;
        end
        CLEAR: begin
          mul_clr_q   <= 1'b0;
          mul_start_q <= 1'b1;
          state_q     <= LAUNCH;
        end
        // mul_done is deliberately not looked at here: it may be left over from the previous op
        LAUNCH: begin
          state_q <= WAIT;
`ifdef MULT_SHARE_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        WAIT: if (mul_done) begin
          rsp_product_q <= mul_product;
          mul_start_q   <= 1'b0;
          rsp_valid_q   <= gnt_oh;
          state_q       <= RESP;
        end
`ifdef MULT_SHARE_TIMEOUT_EN
        else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          rsp_product_q <= '0;
          rsp_err_q     <= 1'b1;
          mul_clr_q     <= 1'b1;
          mul_start_q   <= 1'b0;
          rsp_valid_q   <= gnt_oh;
          state_q       <= RESP;
        end else begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
        end
`endif
        RESP: begin
          mul_clr_q <= 1'b0;
`ifdef MULT_SHARE_TIMEOUT_EN
          rsp_err_q <= 1'b0;
`endif
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_clr     = mul_clr_q;
  assign mul_start   = mul_start_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a small behavioural multiplier model.
// Timeout expectations follow MULT_SHARE_TIMEOUT_EN when it is defined.
module tb_mult_share_ctrl;

  localparam int NREQ = 4;
  localparam int W    = 3;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [2*W-1:0]    rsp_product;
  logic              rsp_err;
  logic [W-1:0]      mul_a, mul_b;
  logic              mul_clr, mul_start;
  logic [2*W-1:0]    mul_product;
  logic              mul_done;

  logic              mdl_done;
  logic [2*W-1:0]    mdl_prod;
  int                mdl_cnt;
  logic              man_en, man_done;
  logic [2*W-1:0]    man_prod;
  logic [NREQ-1:0]   hold;

  int n_checks = 0;
  int n_pass   = 0;
  int oh_bad   = 0;
  int rsp_ids[$];
  int rsp_prods[$];
  int rsp_errs[$];
  int rsp_clrs[$];
  int exp_prod[4] = '{20, 49, 8, 0};

  always #5 clk = ~clk;

  mult_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_clr     (mul_clr),
    .mul_start   (mul_start),
    .mul_product (mul_product),
    .mul_done    (mul_done)
  );

  // Sequential multiplier model: LAT+1 started cycles after a clear, one-cycle done.
  always @(posedge clk) begin
    if (mul_clr) begin
      mdl_cnt  <= 0;
      mdl_done <= 1'b0;
    end else if (mul_start && !mdl_done) begin
      if (mdl_cnt == LAT) begin
        mdl_done <= 1'b1;
        mdl_prod <= 6'(mul_a) * 6'(mul_b);
      end else begin
        mdl_cnt <= mdl_cnt + 1;
      end
    end else begin
      mdl_done <= 1'b0;
    end
  end

  assign mul_done    = man_en ? man_done : mdl_done;
  assign mul_product = man_en ? man_prod : mdl_prod;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) oh_bad++;
    if (req_ready != '0) req_valid = req_valid & (~req_ready | hold);
    if (rsp_valid != '0) begin
      rsp_ids.push_back(oh2idx(rsp_valid));
      rsp_prods.push_back(int'(rsp_product));
      rsp_errs.push_back(int'(rsp_err));
      rsp_clrs.push_back(int'(mul_clr));
    end
  endtask

  task automatic wait_rsps(input int n, input int budget);
    for (int c = 0; c < budget && rsp_ids.size() < n; c++) tick();
  endtask

  task automatic clear_logs();
    rsp_ids.delete(); rsp_prods.delete(); rsp_errs.delete(); rsp_clrs.delete();
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_valid[i]    = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; hold = '0; man_en = 1'b0; man_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; hold = '0;
    man_en = 1'b0; man_done = 1'b0; man_prod = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_product", rsp_product, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_clr", mul_clr, 0);
    chk("rst_mul_start", mul_start, 0);
    reset = 1'b1;

    // Single requester 2x3
    set_req(0, 2, 3);
    tick();
    chk("single_ready", req_ready, 1);
    chk("single_mul_a", mul_a, 2);
    chk("single_mul_b", mul_b, 3);
    chk("single_clr", mul_clr, 1);
    chk("single_start_in_clear", mul_start, 0);
    tick();
    chk("single_clr_drop", mul_clr, 0);
    chk("single_start", mul_start, 1);
    wait_rsps(1, 50);
    chk("single_count", rsp_ids.size(), 1);
    if (rsp_ids.size() == 1) begin
      chk("single_id", rsp_ids[0], 0);
      chk("single_prod", rsp_prods[0], 6);
      chk("single_err", rsp_errs[0], 0);
    end
    chk("single_start_resp", mul_start, 0);
    tick();
    chk("single_rsp_pulse", rsp_valid, 0);
    chk("single_prod_hold", rsp_product, 6);

    // Contention from rr_ptr=0
    do_reset();
    set_req(0, 6, 5);
    set_req(1, 3, 7);
    wait_rsps(2, 100);
    chk("cont_count", rsp_ids.size(), 2);
    if (rsp_ids.size() == 2) begin
      chk("cont_id0", rsp_ids[0], 0);
      chk("cont_prod0", rsp_prods[0], 30);
      chk("cont_id1", rsp_ids[1], 1);
      chk("cont_prod1", rsp_prods[1], 21);
    end
    chk("cont_onehot", oh_bad, 0);

    // Fairness with all four continuously valid
    do_reset();
    hold = '1;
    set_req(0, 4, 5); set_req(1, 7, 7); set_req(2, 2, 4); set_req(3, 0, 7);
    wait_rsps(8, 200);
    req_valid = '0; hold = '0;
    chk("fair_count", rsp_ids.size(), 8);
    if (rsp_ids.size() == 8)
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("fair_id%0d", k), rsp_ids[k], k % 4);
        chk($sformatf("fair_prod%0d", k), rsp_prods[k], exp_prod[k % 4]);
      end
    chk("fair_onehot", oh_bad, 0);
    repeat (4) tick();

    // Reset while WAITing
    do_reset();
    man_en = 1'b1; man_done = 1'b0;
    set_req(0, 2, 3);
    repeat (4) tick();
    chk("mid_start_wait", mul_start, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_start", mul_start, 0);
    chk("mid_rst_clr", mul_clr, 0);
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1; man_en = 1'b0;
    chk("mid_no_rsp", rsp_ids.size(), 0);
    set_req(1, 1, 5);
    set_req(0, 2, 3);
    wait_rsps(2, 100);
    chk("mid_count", rsp_ids.size(), 2);
    if (rsp_ids.size() == 2) begin
      chk("mid_id0", rsp_ids[0], 0);
      chk("mid_prod0", rsp_prods[0], 6);
      chk("mid_id1", rsp_ids[1], 1);
      chk("mid_prod1", rsp_prods[1], 5);
    end
    tick();

    // Stale done through CLEAR/LAUNCH (rr_ptr now 2)
    clear_logs();
    man_en = 1'b1; man_done = 1'b1; man_prod = 6'd63;
    set_req(2, 3, 4);
    tick();
    chk("stale_ready", req_ready, 4);
    tick();
    tick();
    man_done = 1'b0;
    chk("stale_start_wait", mul_start, 1);
    repeat (3) tick();
    chk("stale_no_early_rsp", rsp_ids.size(), 0);
    man_prod = 6'd12; man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("stale_count", rsp_ids.size(), 1);
    if (rsp_ids.size() == 1) begin
      chk("stale_id", rsp_ids[0], 2);
      chk("stale_prod", rsp_prods[0], 12);
    end
    tick();

    // Multiplier never finishes
    clear_logs();
    set_req(3, 1, 1);
`ifdef MULT_SHARE_TIMEOUT_EN
    wait_rsps(1, 200);
    chk("to_count", rsp_ids.size(), 1);
    if (rsp_ids.size() == 1) begin
      chk("to_id", rsp_ids[0], 3);
      chk("to_err", rsp_errs[0], 1);
      chk("to_prod", rsp_prods[0], 0);
      chk("to_clr", rsp_clrs[0], 1);
    end
`else
    repeat (200) tick();
    chk("noto_count", rsp_ids.size(), 0);
    chk("noto_start", mul_start, 1);
    chk("noto_err", rsp_err, 0);
`endif
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
